// File: rtl/pipeline_layer_control_pkg.sv
// Shared encodings for the layer control register bank: SPI opcodes, field
// selectors, overlay modes and the command FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_READ   = 2'd1,
    OP_COMMIT = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    FIELD_MODE        = 3'd0,
    FIELD_SCALE       = 3'd1,
    FIELD_OFFSET_X    = 3'd2,
    FIELD_OFFSET_Y    = 3'd3,
    FIELD_CLIP_LEFT   = 3'd4,
    FIELD_CLIP_RIGHT  = 3'd5,
    FIELD_CLIP_TOP    = 3'd6,
    FIELD_CLIP_BOTTOM = 3'd7
  } field_e;

  localparam logic [1:0] OVL_NONE   = 2'd0;
  localparam logic [1:0] OVL_CHROMA = 2'd1;
  localparam logic [1:0] OVL_DIRECT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA_HI,
    S_DATA_LO,
    S_DONE
  } state_e;

endpackage

// File: rtl/pipeline_layer_control_spi_byte_slave.sv
// Mode-0 SPI byte slave in the clk domain: input synchronisers, SCK edge
// detection, MSB-first RX/TX shifters and a bit counter.
module spi_byte_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       ss_i,
  input  logic       mosi_i,
  input  logic [7:0] tx_byte_i,
  output logic       miso_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       tx_load_o,
  output logic       frame_active_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic       sck_prev_q, active_q, rx_valid_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q, rx_byte_q, tx_shift_q;
  logic       sck_s, ss_s, mosi_s, sck_rise, sck_fall, start;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign start    = !ss_s && !active_q;
  assign sck_rise = active_q && sck_s && !sck_prev_q;
  assign sck_fall = active_q && !sck_s && sck_prev_q;
  // Next byte is presented at SS fall and on the falling edge after each 8th bit
  assign tx_load_o = start || (sck_fall && bit_cnt_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      sck_sync_q[0]  <= sck_i;
      ss_sync_q[0]   <= ss_i;
      mosi_sync_q[0] <= mosi_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sck_sync_q[i]  <= sck_sync_q[i-1];
        ss_sync_q[i]   <= ss_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
      end
      sck_prev_q <= sck_s;
      active_q   <= !ss_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_shift_q <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        rx_shift_q <= {rx_shift_q[6:0], mosi_s};
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q  <= {rx_shift_q[6:0], mosi_s};
          rx_valid_q <= 1'b1;
        end
      end
      if (tx_load_o) begin
        tx_shift_q <= tx_byte_i;
      end else if (sck_fall) begin
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      end
    end
  end

  assign miso_o         = active_q & tx_shift_q[7];
  assign rx_byte_o      = rx_byte_q;
  assign rx_valid_o     = rx_valid_q;
  assign frame_active_o = active_q;

endmodule

// File: rtl/pipeline_layer_control.sv
// SPI-programmable, double-buffered per-layer control bank: SPI writes land in
// shadow registers, copied to the active outputs at a committed frame_start.
module pipeline_layer_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned PRECISION   = 11,
  parameter int unsigned LAYER_COUNT = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 hw_spi_clk,
  input  logic                                 hw_spi_ss,
  input  logic                                 hw_spi_mosi,
  output logic                                 hw_spi_miso,
  output logic [2*LAYER_COUNT-1:0]             ctrl_overlay_mode,
  output logic [2*LAYER_COUNT-1:0]             ctrl_fg_scale,
  output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_x,
  output logic [(PRECISION+1)*LAYER_COUNT-1:0] ctrl_fg_offset_y,
  output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_left,
  output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_right,
  output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_top,
  output logic [PRECISION*LAYER_COUNT-1:0]     ctrl_fg_clip_bottom,
  output logic                                 commit_pending,
  output logic                                 cmd_error
);

  localparam int unsigned OW = PRECISION + 1;

  logic [7:0] rx_byte, tx_byte, hi_q, hi_d, rd_lo_q;
  logic       rx_valid, tx_load, frame_active;
  state_e     state_q, state_d;
  op_e        op_q, op_d, rx_op;
  field_e     field_q, field_d, rx_field;
  logic [2:0] layer_q, layer_d, rx_layer;
  logic       layer_ok_q, layer_ok_d, rx_layer_ok;
  logic       shadow_we, commit_set, cmd_error_d, cmd_error_q, pending_q;
  logic [15:0] rd_val;

  logic [1:0]           sh_mode_q [LAYER_COUNT], act_mode_q [LAYER_COUNT];
  logic [1:0]           sh_scale_q[LAYER_COUNT], act_scale_q[LAYER_COUNT];
  logic [OW-1:0]        sh_offx_q [LAYER_COUNT], act_offx_q [LAYER_COUNT];
  logic [OW-1:0]        sh_offy_q [LAYER_COUNT], act_offy_q [LAYER_COUNT];
  logic [PRECISION-1:0] sh_clip_q [LAYER_COUNT][4], act_clip_q[LAYER_COUNT][4];

  spi_byte_slave #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
    .clk(clk), .rst(rst), .sck_i(hw_spi_clk), .ss_i(hw_spi_ss), .mosi_i(hw_spi_mosi),
    .tx_byte_i(tx_byte), .miso_o(hw_spi_miso), .rx_byte_o(rx_byte),
    .rx_valid_o(rx_valid), .tx_load_o(tx_load), .frame_active_o(frame_active)
  );

  assign rx_op       = op_e'(rx_byte[7:6]);
  assign rx_layer    = rx_byte[5:3];
  assign rx_field    = field_e'(rx_byte[2:0]);
  assign rx_layer_ok = {1'b0, rx_layer} < 4'(LAYER_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      field_q    <= FIELD_MODE;
      layer_q    <= '0;
      layer_ok_q <= 1'b0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      field_q    <= field_d;
      layer_q    <= layer_d;
      layer_ok_q <= layer_ok_d;
      hi_q       <= hi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    field_d    = field_q;
    layer_d    = layer_q;
    layer_ok_d = layer_ok_q;
    hi_d       = hi_q;
    if (!frame_active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: if (rx_valid) begin
          op_d       = rx_op;
          layer_d    = rx_layer;
          field_d    = rx_field;
          layer_ok_d = rx_layer_ok;
          state_d    = (rx_op == OP_WRITE || rx_op == OP_READ) ? S_DATA_HI : S_DONE;
        end
        S_DATA_HI: if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: if (rx_valid) begin
          field_d = field_e'(field_q + 3'd1);
          state_d = S_DATA_HI;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shadow_we   = 1'b0;
    commit_set  = 1'b0;
    cmd_error_d = 1'b0;
    tx_byte     = {pending_q, 4'b0000, 3'(LAYER_COUNT - 1)};
    case (state_q)
      S_CMD: if (rx_valid) begin
        commit_set  = (rx_op == OP_COMMIT);
        cmd_error_d = (rx_op == OP_WRITE || rx_op == OP_READ) && !rx_layer_ok;
      end
      S_DATA_HI: tx_byte = rd_val[15:8];
      S_DATA_LO: begin
        tx_byte   = rd_lo_q;
        shadow_we = rx_valid && op_q == OP_WRITE && layer_ok_q;
      end
      S_DONE:  tx_byte = '0;
      default: ;
    endcase
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned l = 0; l < LAYER_COUNT; l++) begin
      if (op_q == OP_READ && layer_ok_q && layer_q == 3'(l)) begin
        case (field_q)
          FIELD_MODE:     rd_val = 16'(sh_mode_q[l]);
          FIELD_SCALE:    rd_val = 16'(sh_scale_q[l]);
          FIELD_OFFSET_X: rd_val = 16'($signed(sh_offx_q[l]));
          FIELD_OFFSET_Y: rd_val = 16'($signed(sh_offy_q[l]));
          default:        rd_val = 16'(sh_clip_q[l][field_q[1:0]]);
        endcase
      end
    end
  end

  // High byte goes straight to the shifter; low byte is held for DATA_LO
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_lo_q <= '0;
    end else if (tx_load && state_q == S_DATA_HI) begin
      rd_lo_q <= rd_val[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      for (int unsigned l = 0; l < LAYER_COUNT; l++) begin
        sh_mode_q[l]  <= '0;  act_mode_q[l]  <= '0;
        sh_scale_q[l] <= '0;  act_scale_q[l] <= '0;
        sh_offx_q[l]  <= '0;  act_offx_q[l]  <= '0;
        sh_offy_q[l]  <= '0;  act_offy_q[l]  <= '0;
        for (int unsigned c = 0; c < 4; c++) begin
          sh_clip_q[l][c]  <= '0;
          act_clip_q[l][c] <= '0;
        end
      end
    end else begin
      cmd_error_q <= cmd_error_d;
      if (commit_set) pending_q <= 1'b1;
      else if (frame_start) pending_q <= 1'b0;
      // A same-cycle shadow write lands after the copy reads the old shadow
      if (frame_start && pending_q) begin
        act_mode_q  <= sh_mode_q;
        act_scale_q <= sh_scale_q;
        act_offx_q  <= sh_offx_q;
        act_offy_q  <= sh_offy_q;
        act_clip_q  <= sh_clip_q;
      end
      if (shadow_we) begin
        for (int unsigned l = 0; l < LAYER_COUNT; l++) begin
          if (layer_q == 3'(l)) begin
            case (field_q)
              FIELD_MODE:     sh_mode_q[l]  <= 2'(rx_byte);
              FIELD_SCALE:    sh_scale_q[l] <= 2'(rx_byte);
              FIELD_OFFSET_X: sh_offx_q[l]  <= OW'({hi_q, rx_byte});
              FIELD_OFFSET_Y: sh_offy_q[l]  <= OW'({hi_q, rx_byte});
              default:        sh_clip_q[l][field_q[1:0]] <= PRECISION'({hi_q, rx_byte});
            endcase
          end
        end
      end
    end
  end

  for (genvar g = 0; g < LAYER_COUNT; g++) begin : g_out
    assign ctrl_overlay_mode[g*2 +: 2]               = act_mode_q[g];
    assign ctrl_fg_scale[g*2 +: 2]                   = act_scale_q[g];
    assign ctrl_fg_offset_x[g*OW +: OW]              = act_offx_q[g];
    assign ctrl_fg_offset_y[g*OW +: OW]              = act_offy_q[g];
    assign ctrl_fg_clip_left[g*PRECISION +: PRECISION]   = act_clip_q[g][0];
    assign ctrl_fg_clip_right[g*PRECISION +: PRECISION]  = act_clip_q[g][1];
    assign ctrl_fg_clip_top[g*PRECISION +: PRECISION]    = act_clip_q[g][2];
    assign ctrl_fg_clip_bottom[g*PRECISION +: PRECISION] = act_clip_q[g][3];
  end

  assign commit_pending = pending_q;
  assign cmd_error      = cmd_error_q;

endmodule
